itof_pipe: RTL and testbench

Pipelined signed 32-bit integer to IEEE-754 single-precision converter, the int-to-float direction of the FPU's float/integer conversion path. It sits in the FPU beside the float-to-integral rounding units. It accepts one two's-complement word per cycle over a valid/ready handshake. Three cycles later it returns the correctly packed float.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/lzc32.sv | 18 +
 rtl/itof_pipe.sv | 112 +++++++++++
 tb/tb_itof_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 field widths, exponent bias and the
// stage payload structs used by the int-to-float pipeline.
package fpu_pkg;

    localparam int EXP_W        = 8;
    localparam int FRAC_W       = 23;
    localparam int BIAS         = 127;
    localparam int INT_EXP_BASE = BIAS + 31;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Raw request captured at acceptance.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } itofIn_t;

    typedef struct packed {
        logic        valid;
        logic        sign;
        logic [31:0] mag;
    } itofS1_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             zero;
        logic [EXP_W-1:0] exp;
        logic [31:0]      norm;
    } itofS2_t;

endpackage

// File: rtl/lzc32.sv
// Combinational leading-zero counter for a 32-bit word; an all-zero
// input reports 32.
module lzc32 (
    input  logic [31:0] data_i,
    output logic [5:0]  count_o
);

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        count_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (data_i[i]) begin
                count_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Pipelined signed int32 to FP32 converter with a global-stall handshake.
// Define ITOF_RNE_EN for round-to-nearest-even; otherwise truncates toward zero.
module itof_pipe
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    itofIn_t s0_q, s0_d;
    itofS1_t s1_q, s1_d;
    itofS2_t s2_q, s2_d;
    logic    outValid_q, outValid_d;
    fp32_t   outData_q, outData_d;

    logic       stall;
    logic [5:0] lz;

    assign stall     = outValid_q & ~out_ready;
    assign in_ready  = ~stall & ~rst;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;

    always_comb begin
        s0_d.valid = in_valid & in_ready;
        s0_d.data  = in_data;

        s1_d.valid = s0_q.valid;
        s1_d.sign  = s0_q.data[31];
        s1_d.mag   = s0_q.data[31] ? (~s0_q.data + 32'd1) : s0_q.data;
    end

    lzc32 uLzc (
        .data_i  (s1_q.mag),
        .count_o (lz)
    );

    always_comb begin
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.zero  = (s1_q.mag == 32'd0);
        s2_d.exp   = 8'(INT_EXP_BASE) - {2'b00, lz};
        s2_d.norm  = s1_q.mag << lz;
    end

    logic [FRAC_W-1:0] fracTrunc;
    logic [FRAC_W-1:0] fracOut;
    logic [EXP_W-1:0]  expOut;
    logic              unusedNorm;

`ifdef ITOF_RNE_EN
    logic              guardBit;
    logic              stickyBit;
    logic              roundUp;
    logic              carry;
    logic [FRAC_W-1:0] fracRnd;

    // A carry out of the fraction can only come from an all-ones fraction,
    // so the rounded value is exactly the next power of two.
    always_comb begin
        fracTrunc        = s2_q.norm[30:8];
        guardBit         = s2_q.norm[7];
        stickyBit        = |s2_q.norm[6:0];
        roundUp          = guardBit & (stickyBit | fracTrunc[0]);
        {carry, fracRnd} = {1'b0, fracTrunc} + {{FRAC_W{1'b0}}, roundUp};
        fracOut          = carry ? '0 : fracRnd;
        expOut           = carry ? (s2_q.exp + 8'd1) : s2_q.exp;
        unusedNorm       = s2_q.norm[31];
    end
`else
    always_comb begin
        fracTrunc  = s2_q.norm[30:8];
        fracOut    = fracTrunc;
        expOut     = s2_q.exp;
        unusedNorm = ^{s2_q.norm[31], s2_q.norm[7:0]};
    end
`endif

    // Zero bypasses packing so it never shows up as -0 or with exponent 126.
    always_comb begin
        outValid_d = s2_q.valid;
        outData_d  = '0;
        if (!s2_q.zero) begin
            outData_d.sign = s2_q.sign;
            outData_d.exp  = expOut;
            outData_d.frac = fracOut;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else if (!stall) begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Directed and streaming checks for itof_pipe; expectations follow ITOF_RNE_EN.
module tb_itof_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] bpVals [10];

`ifdef ITOF_RNE_EN
    localparam logic [31:0] EXP_MAXPOS    = 32'h4F000000;
    localparam logic [31:0] EXP_TIEUP     = 32'h4B800002;
    localparam logic [31:0] EXP_TIEUP_NEG = 32'hCB800002;
`else
    localparam logic [31:0] EXP_MAXPOS    = 32'h4EFFFFFF;
    localparam logic [31:0] EXP_TIEUP     = 32'h4B800001;
    localparam logic [31:0] EXP_TIEUP_NEG = 32'hCB800001;
`endif

    itof_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: locate the MSB, shift into 24 bits, round on the remainder.
    function automatic logic [31:0] refItof(input logic [31:0] x);
        longint mag;
        longint shifted;
        int     p;
        int     e;
        logic   s;
`ifdef ITOF_RNE_EN
        longint rem;
        longint half;
`endif
        if (x == 32'd0) return 32'd0;
        s   = x[31];
        mag = s ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
        p   = 0;
        for (int i = 0; i < 33; i++) if (mag[i]) p = i;
        e = 127 + p;
        if (p <= 23) begin
            shifted = mag << (23 - p);
        end else begin
            shifted = mag >> (p - 23);
`ifdef ITOF_RNE_EN
            rem  = mag & ((64'd1 << (p - 23)) - 1);
            half = 64'd1 << (p - 24);
            if (rem > half || (rem == half && shifted[0])) shifted = shifted + 1;
            if (shifted == (64'd1 << 24)) begin
                shifted = shifted >> 1;
                e = e + 1;
            end
`endif
        end
        return {s, 8'(e), 23'(shifted & 64'h7FFFFF)};
    endfunction

    function automatic logic [31:0] genRand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v = v >> $urandom_range(0, 31);
            1: v = ~(v >> $urandom_range(0, 31)) + 32'd1;
            2: begin
                v = {7'd0, 1'b1, 23'($urandom), 1'b1};
                if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++;
        if (out_data !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_out_data: got %h expected 00000000", out_data); end
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        rst = 1'b0;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready_high: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    // One isolated conversion: result must appear exactly three edges after acceptance.
    task automatic convertOne(input string name, input logic [31:0] data, input logic [31:0] expected);
        in_valid = 1'b1; in_data = data; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 32'd0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k < 3) begin
                compared++;
                if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL %s_early_valid: cycle %0d got %b expected 0", name, k, out_valid); end
            end
        end
        compared++;
        if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL %s_valid: got %b expected 1", name, out_valid); end
        compared++;
        if (out_data !== expected) begin mismatched++; $display("[TB] FAIL %s_data: got %h expected %h", name, out_data, expected); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        convertOne("one",     32'd1,          32'h3F800000);
        convertOne("neg_one", 32'hFFFFFFFF,   32'hBF800000);
        convertOne("zero",    32'd0,          32'h00000000);
        convertOne("two_neg", 32'hFFFFFFFE,   32'hC0000000);
        convertOne("exact24", 32'h00FFFFFF,   32'h4B7FFFFF);
    endtask

    task automatic test_extremes();
        convertOne("int_min", 32'h80000000, 32'hCF000000);
        convertOne("int_max", 32'h7FFFFFFF, EXP_MAXPOS);
        convertOne("pow30",   32'h40000000, 32'h4E800000);
    endtask

    task automatic test_rounding();
        convertOne("tie_down",     32'd16777217, 32'h4B800000);
        convertOne("tie_down_neg", 32'hFEFFFFFF, 32'hCB800000);
        convertOne("tie_up",       32'd16777219, EXP_TIEUP);
        convertOne("tie_up_neg",   32'hFEFFFFFD, EXP_TIEUP_NEG);
    endtask

    // Streams values while keeping a valid-bit timing model and an in-order scoreboard.
    task automatic test_stream(input string name, input int count, input bit randomData,
                               input int validPct, input int readyPct);
        logic [31:0] pending [$];
        bit          mv [4];
        int          sent;
        int          cycles;
        bit          stl;
        bit          acc;
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        sent   = 0;
        cycles = 0;
        while ((sent < count || pending.size() > 0) && cycles < count * 20 + 100) begin
            compared++;
            if (out_valid !== mv[3]) begin mismatched++; $display("[TB] FAIL %s_out_valid: cycle %0d got %b expected %b", name, cycles, out_valid, mv[3]); end
            if (mv[3] && pending.size() > 0) begin
                compared++;
                if (out_data !== pending[0]) begin mismatched++; $display("[TB] FAIL %s_out_data: cycle %0d got %h expected %h", name, cycles, out_data, pending[0]); end
            end
            out_ready = ($urandom_range(0, 99) < readyPct);
            if (sent < count && $urandom_range(0, 99) < validPct) begin
                in_valid = 1'b1;
                in_data  = randomData ? genRand() : bpVals[sent];
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end
            #1;
            stl = mv[3] && !out_ready;
            compared++;
            if (in_ready !== !stl) begin mismatched++; $display("[TB] FAIL %s_in_ready: cycle %0d got %b expected %b", name, cycles, in_ready, !stl); end
            acc = in_valid && !stl;
            if (mv[3] && out_ready && pending.size() > 0) void'(pending.pop_front());
            if (!stl) begin
                mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = mv[0]; mv[0] = acc;
            end
            if (acc) begin
                pending.push_back(refItof(in_data));
                sent++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        compared++;
        if (sent < count || pending.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL %s_timeout: sent %0d of %0d, %0d outstanding", name, sent, count, pending.size());
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        test_stream("backpressure", 10, 1'b0, 100, 50);
    endtask

    task automatic test_random_sweep();
        test_stream("random", 3000, 1'b1, 70, 70);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] vals [3];
        vals[0] = 32'd5; vals[1] = 32'hFFFFFFF9; vals[2] = 32'd100;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = vals[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_in_ready_low: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
        compared++;
        if (out_data !== 32'd0) begin mismatched++; $display("[TB] FAIL midrst_out_data: got %h expected 00000000", out_data); end
        rst = 1'b0;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_in_ready_high: got %b expected 1", in_ready); end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            compared++;
            if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_ghost_output: cycle %0d got valid %b data %h expected no output", k, out_valid, out_data); end
        end
    endtask

    initial begin
        bpVals[0] = 32'd1;          bpVals[1] = 32'hFFFFFFFF;
        bpVals[2] = 32'd0;          bpVals[3] = 32'd16777217;
        bpVals[4] = 32'd16777219;   bpVals[5] = 32'hFEFFFFFD;
        bpVals[6] = 32'h7FFFFFFF;   bpVals[7] = 32'h80000000;
        bpVals[8] = 32'd123456789;  bpVals[9] = 32'hFFFFFFD6;
        test_reset();
        test_basic();
        test_extremes();
        test_rounding();
        test_back_to_back();
        test_reset_midflight();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
